// File: rtl/grid_io_bank_pkg.sv
// Shared types and constants for the grid_io_bank pad tile.
// Optional readback is enabled with the GRID_IO_BANK_READBACK_EN macro.
package grid_io_bank_pkg;

    localparam int CFG_BITS = 3;

    typedef enum logic [1:0] {
        IO_MODE_OFF   = 2'b00,
        IO_MODE_IN    = 2'b01,
        IO_MODE_OUT   = 2'b10,
        IO_MODE_BIDIR = 2'b11
    } io_mode_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        LOADED  = 2'd2,
        ERROR   = 2'd3
    } load_state_t;

endpackage

// File: rtl/grid_io_bank_if.sv
// Configuration chain bundle: serial head/tail, shift/commit controls and status.
// cfg_readback exists only when GRID_IO_BANK_READBACK_EN is defined.
interface grid_io_bank_if;
    logic ccff_head;
    logic ccff_en;
    logic ccff_commit;
    logic ccff_tail;
    logic cfg_done;
    logic cfg_err;
`ifdef GRID_IO_BANK_READBACK_EN
    logic cfg_readback;
`endif

    modport master (
        output ccff_head, ccff_en, ccff_commit,
`ifdef GRID_IO_BANK_READBACK_EN
        output cfg_readback,
`endif
        input  ccff_tail, cfg_done, cfg_err
    );

    modport slave (
        input  ccff_head, ccff_en, ccff_commit,
`ifdef GRID_IO_BANK_READBACK_EN
        input  cfg_readback,
`endif
        output ccff_tail, cfg_done, cfg_err
    );
endinterface

// File: rtl/grid_io_bank_pad.sv
// One GPIO pad: decodes its 3-bit active config into tristate drive and
// fabric-side input, with an optional input register.
module grid_io_bank_pad
    import grid_io_bank_pkg::*;
(
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic [CFG_BITS-1:0] cfg,
    input  logic                outpad,
    input  logic                oe,
    output logic                inpad,
    inout  wire                 pad
);

    io_mode_t mode;
    logic     drive;
    logic     listen;
    logic     in_reg;

    assign mode   = io_mode_t'(cfg[2:1]);
    assign drive  = (mode == IO_MODE_OUT) || ((mode == IO_MODE_BIDIR) && oe);
    assign listen = (mode == IO_MODE_IN) || (mode == IO_MODE_BIDIR);

    assign pad = drive ? outpad : 1'bz;

    // Gated by listen so a floating pad never reaches the flop in OFF/OUT.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            in_reg <= 1'b0;
        end else begin
            in_reg <= listen & pad;
        end
    end

    assign inpad = listen & (cfg[0] ? in_reg : pad);

endmodule

// File: rtl/grid_io_bank.sv
// I/O bank tile: scan-chain shadow register, atomic commit into the active
// config, load FSM, and NUM_PADS pad slices. Readback: GRID_IO_BANK_READBACK_EN.
module grid_io_bank
    import grid_io_bank_pkg::*;
#(
    parameter int NUM_PADS = 8,
    parameter int CNT_W    = $clog2(NUM_PADS*CFG_BITS+1)
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    grid_io_bank_if.slave       cfg_bus,
    inout  wire  [0:NUM_PADS-1] gfpga_pad_GPIO_PAD,
    input  logic [NUM_PADS-1:0] pin_outpad,
    input  logic [NUM_PADS-1:0] pin_oe,
    output logic [NUM_PADS-1:0] pin_inpad
);

    localparam int T = NUM_PADS * CFG_BITS;

    logic [T-1:0]     shadow_reg;
    logic [T-1:0]     active_reg;
    logic [CNT_W-1:0] count_reg;
    load_state_t      state_reg;
    logic             done_reg;
    logic             err_reg;

    logic en;
    logic commit;
    logic rb;
    logic conflict;

    assign en     = cfg_bus.ccff_en;
    assign commit = cfg_bus.ccff_commit;
`ifdef GRID_IO_BANK_READBACK_EN
    assign rb     = cfg_bus.cfg_readback;
`else
    assign rb     = 1'b0;
`endif
    assign conflict = (en & commit) | (rb & (en | commit));

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            shadow_reg <= '0;
            active_reg <= '0;
            count_reg  <= '0;
            state_reg  <= EMPTY;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else if (conflict) begin
            err_reg   <= 1'b1;
            state_reg <= ERROR;
            done_reg  <= 1'b0;
        end else if (en) begin
            // The chain shifts in every state, including ERROR and overflow.
            shadow_reg <= {shadow_reg[T-2:0], cfg_bus.ccff_head};
            case (state_reg)
                EMPTY, LOADING: begin
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CNT_W'(T-1)) begin
                        state_reg <= LOADED;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= LOADING;
                    end
                end
                LOADED: begin
                    err_reg   <= 1'b1;
                    state_reg <= ERROR;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ERROR;
                end
            endcase
        end else if (commit) begin
            if (state_reg == LOADED) begin
                active_reg <= shadow_reg;
                count_reg  <= '0;
                state_reg  <= EMPTY;
            end else begin
                err_reg   <= 1'b1;
                state_reg <= ERROR;
            end
            done_reg <= 1'b0;
        end else if (rb) begin
            // Readback only makes sense before any new bits enter the chain.
            if (state_reg == EMPTY) begin
                shadow_reg <= active_reg;
            end else begin
                err_reg <= 1'b1;
            end
        end
    end

    assign cfg_bus.ccff_tail = shadow_reg[T-1];
    assign cfg_bus.cfg_done  = done_reg;
    assign cfg_bus.cfg_err   = err_reg;

    generate
        for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            grid_io_bank_pad u_pad (
                .prog_clk (prog_clk),
                .pReset_n (pReset_n),
                .cfg      (active_reg[CFG_BITS*gi +: CFG_BITS]),
                .outpad   (pin_outpad[gi]),
                .oe       (pin_oe[gi]),
                .inpad    (pin_inpad[gi]),
                .pad      (gfpga_pad_GPIO_PAD[gi])
            );
        end
    endgenerate

endmodule
